mult_share_arbiter: RTL and testbench

- Shares one iterative 8x8 shift-add multiplier datapath between NREQ requesters.
- Arbitrates with round-robin priority and sequences the multiply one multiplier bit per cycle.
- Returns the 16-bit product tagged with the requester ID on a valid/ready response channel.
- Sits between the compute clients and the arithmetic unit. Its products are bit-identical to the combinational 8x8 unsigned product.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/mult_share_arbiter_rr.sv | 32 +++
 rtl/mult_share_arbiter.sv | 110 +++++++++++
 tb/tb_mult_share_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared shift-add multiplier.
package mult_share_pkg;

   localparam int DEF_W    = 8;
   localparam int DEF_NREQ = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            en,
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (en && !found && req_valid[idx]) begin
            found     = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// One iterative 8x8 shift-add multiplier shared by NREQ round-robin clients.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   parameter  int W    = DEF_W,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [2*W-1:0]  rsp_p,
   output logic [IDW-1:0]  rsp_id,
   output logic            busy
);

   localparam int PW = prod_w(W);
   localparam int CW = $clog2(W + 1);

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  acc_q, acc_d;
   logic [PW-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]   b_sh_q, b_sh_d;
   logic [IDW-1:0] id_q, id_d;

   logic            arb_en;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;

   // Reset also masks grants so req_ready is 0 for the whole reset window.
   assign arb_en = (state_q == IDLE) && !rst;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .en        (arb_en),
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
      acc_d    = acc_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      id_d     = id_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               a_sh_d  = {{W{1'b0}}, req_a[gnt_idx*W +: W]};
               b_sh_d  = req_b[gnt_idx*W +: W];
               id_d    = gnt_idx;
               acc_d   = '0;
               count_d = '0;
               rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ?
                          '0 : gnt_idx + IDW'(1);
               state_d = MUL;
            end
         end
         MUL: begin
            if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
            a_sh_d  = a_sh_q << 1;
            b_sh_d  = b_sh_q >> 1;
            count_d = count_q + CW'(1);
            // Fixed W-cycle latency: no early exit when b_sh drains.
            if (count_q == CW'(W - 1)) state_d = DONE;
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         id_q     <= id_d;
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = (state_q == DONE);
   assign rsp_p     = rsp_valid ? acc_q : '0;
   assign rsp_id    = rsp_valid ? id_q : '0;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NREQ=4, W=8).
module tb_mult_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_p;
   logic [1:0]  rsp_id;
   logic        busy;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   mult_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on a lone requester and collect what comes back.
   task automatic issue_op(input int id, input logic [7:0] a,
                           input logic [7:0] b,
                           output logic [3:0] gnt,
                           output logic [15:0] p,
                           output logic [1:0] rid,
                           output int lat);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      rsp_ready = 1'b1;
      #1;
      gnt = req_ready;
      cyc();
      req_valid = '0;
      req_a = '1;
      req_b = '1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         cyc();
         lat++;
      end
      p = rsp_p;
      rid = rsp_id;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'hF;
      req_a = 32'h1234_5678;
      req_b = 32'h9ABC_DEF0;
      rsp_ready = 1'b0;
      repeat (2) cyc();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_mis++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid);
      end
      n_cmp++;
      if (rsp_p !== 16'd0) begin
         n_mis++; $display("FAIL reset_rsp_p: got %0d want 0", rsp_p);
      end
      n_cmp++;
      if (rsp_id !== 2'd0) begin
         n_mis++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_mis++; $display("FAIL reset_busy: got %0b want 0", busy);
      end
      n_cmp++;
      if (req_ready !== 4'b0000) begin
         n_mis++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      req_valid = '0;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      int          ids [4] = '{0, 2, 1, 3};
      logic [7:0]  as  [4] = '{8'd13, 8'd255, 8'd200, 8'd0};
      logic [7:0]  bs  [4] = '{8'd11, 8'd255, 8'd0, 8'd77};
      logic [15:0] ps  [4] = '{16'd143, 16'hFE01, 16'd0, 16'd0};
      logic [3:0]  g, eg;
      logic [15:0] p;
      logic [1:0]  rid;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         issue_op(ids[i], as[i], bs[i], g, p, rid, lat);
         eg = 4'b0001 << ids[i];
         n_cmp++;
         if (g !== eg) begin
            n_mis++; $display("FAIL single_grant[%0d]: got %b want %b", i, g, eg);
         end
         n_cmp++;
         if (lat !== 8) begin
            n_mis++; $display("FAIL single_latency[%0d]: got %0d want 8", i, lat);
         end
         n_cmp++;
         if (p !== ps[i]) begin
            n_mis++; $display("FAIL single_product[%0d]: got %0d want %0d", i, p, ps[i]);
         end
         n_cmp++;
         if (rid !== 2'(ids[i])) begin
            n_mis++; $display("FAIL single_id[%0d]: got %0d want %0d", i, rid, ids[i]);
         end
      end
   endtask

   task automatic test_contention();
      logic [7:0]  ca [4] = '{8'd13, 8'd250, 8'd99, 8'd1};
      logic [7:0]  cb [4] = '{8'd11, 8'd3, 8'd128, 8'd255};
      logic [15:0] cp [4] = '{16'd143, 16'd750, 16'd12672, 16'd255};
      logic [3:0]  eg;
      int          gt [5];
      int          t, guard, j;
      rst = 1'b1;
      req_valid = '0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = ca[i];
         req_b[i*8 +: 8] = cb[i];
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      rst = 1'b0;
      #1;
      t = 0;
      for (int k = 0; k < 5; k++) begin
         j = k % 4;
         guard = 0;
         while (req_ready == 4'b0000 && guard < 30) begin
            cyc(); t++; guard++;
         end
         eg = 4'b0001 << j;
         n_cmp++;
         if (req_ready !== eg) begin
            n_mis++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, eg);
         end
         gt[k] = t;
         if (k > 0) begin
            n_cmp++;
            if (gt[k] - gt[k-1] !== 10) begin
               n_mis++;
               $display("FAIL rr_interval[%0d]: got %0d want 10", k, gt[k] - gt[k-1]);
            end
         end
         cyc(); t++;
         guard = 0;
         while (!rsp_valid && guard < 30) begin
            cyc(); t++; guard++;
         end
         n_cmp++;
         if (rsp_p !== cp[j]) begin
            n_mis++; $display("FAIL rr_product[%0d]: got %0d want %0d", k, rsp_p, cp[j]);
         end
         n_cmp++;
         if (rsp_id !== 2'(j)) begin
            n_mis++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, j);
         end
      end
      req_valid = '0;
      cyc();
   endtask

   task automatic test_backpressure();
      int guard;
      req_valid = 4'b0010;
      req_a[15:8] = 8'd21;
      req_b[15:8] = 8'd5;
      rsp_ready = 1'b0;
      #1;
      cyc();
      req_valid = 4'b1000;
      req_a[31:24] = 8'd3;
      req_b[31:24] = 8'd4;
      req_a[15:8] = 8'hFF;
      guard = 0;
      while (!rsp_valid && guard < 20) begin
         cyc(); guard++;
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_p !== 16'd105 || rsp_id !== 2'd1) begin
            n_mis++;
            $display("FAIL bp_hold[%0d]: got v=%0b p=%0d id=%0d want v=1 p=105 id=1",
                     i, rsp_valid, rsp_p, rsp_id);
         end
         n_cmp++;
         if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL bp_block[%0d]: got ready=%b busy=%0b want 0000/1",
                     i, req_ready, busy);
         end
         cyc();
      end
      rsp_ready = 1'b1;
      #1;
      cyc();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_mis++;
         $display("FAIL bp_release: got v=%0b busy=%0b want 0/0", rsp_valid, busy);
      end
      n_cmp++;
      if (req_ready !== 4'b1000) begin
         n_mis++; $display("FAIL bp_next_grant: got %b want 1000", req_ready);
      end
      cyc();
      req_valid = '0;
      guard = 0;
      while (!rsp_valid && guard < 20) begin
         cyc(); guard++;
      end
      n_cmp++;
      if (rsp_p !== 16'd12 || rsp_id !== 2'd3) begin
         n_mis++;
         $display("FAIL bp_next_result: got p=%0d id=%0d want 12/3", rsp_p, rsp_id);
      end
      cyc();
   endtask

   task automatic test_fairness();
      int guard;
      req_valid = 4'b1000;
      req_a[31:24] = 8'd5;
      req_b[31:24] = 8'd6;
      rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 4'b1000) begin
         n_mis++; $display("FAIL fair_first: got %b want 1000", req_ready);
      end
      cyc();
      repeat (3) cyc();
      req_valid[1] = 1'b1;
      req_a[15:8] = 8'd9;
      req_b[15:8] = 8'd10;
      guard = 0;
      while (!rsp_valid && guard < 20) begin
         cyc(); guard++;
      end
      n_cmp++;
      if (rsp_p !== 16'd30 || rsp_id !== 2'd3) begin
         n_mis++;
         $display("FAIL fair_r3: got p=%0d id=%0d want 30/3", rsp_p, rsp_id);
      end
      cyc();
      n_cmp++;
      if (req_ready !== 4'b0010) begin
         n_mis++; $display("FAIL fair_r1_grant: got %b want 0010", req_ready);
      end
      cyc();
      req_valid[1] = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 20) begin
         cyc(); guard++;
      end
      n_cmp++;
      if (rsp_p !== 16'd90 || rsp_id !== 2'd1) begin
         n_mis++;
         $display("FAIL fair_r1: got p=%0d id=%0d want 90/1", rsp_p, rsp_id);
      end
      cyc();
      n_cmp++;
      if (req_ready !== 4'b1000) begin
         n_mis++; $display("FAIL fair_r3_again: got %b want 1000", req_ready);
      end
      req_valid = '0;
      #1;
      cyc();
   endtask

   task automatic test_reset_mid();
      logic        seen;
      logic [3:0]  g;
      logic [15:0] p;
      logic [1:0]  rid;
      int          lat;
      req_valid = 4'b0001;
      req_a[7:0] = 8'd7;
      req_b[7:0] = 8'd9;
      rsp_ready = 1'b1;
      #1;
      cyc();
      req_valid = '0;
      repeat (3) cyc();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_mis++; $display("FAIL mid_busy: got %0b want 1", busy);
      end
      rst = 1'b1;
      req_valid = 4'b0100;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_p !== 16'd0 ||
          rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
         n_mis++;
         $display("FAIL mid_reset_outs: got v=%0b b=%0b p=%0d id=%0d r=%b want all 0",
                  rsp_valid, busy, rsp_p, rsp_id, req_ready);
      end
      cyc();
      rst = 1'b0;
      req_valid = '0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         seen = seen | rsp_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_mis++; $display("FAIL mid_no_rsp: got %0b want 0", seen);
      end
      issue_op(0, 8'd7, 8'd9, g, p, rid, lat);
      n_cmp++;
      if (p !== 16'd63 || rid !== 2'd0 || lat !== 8) begin
         n_mis++;
         $display("FAIL mid_fresh: got p=%0d id=%0d lat=%0d want 63/0/8", p, rid, lat);
      end
   endtask

   task automatic test_sweep();
      logic [7:0]  a, b;
      logic [15:0] e;
      logic [3:0]  g;
      logic [15:0] p;
      logic [1:0]  rid;
      int          lat;
      for (int i = 0; i < 200; i++) begin
         a = 8'(i * 37 + 3);
         b = 8'(i * 91 + 5);
         e = {8'h00, a} * {8'h00, b};
         issue_op(i % 4, a, b, g, p, rid, lat);
         n_cmp++;
         if (p !== e || lat !== 8) begin
            n_mis++;
            $display("FAIL sweep_product[%0d]: got %0d lat %0d want %0d lat 8 (a=%0d b=%0d)",
                     i, p, lat, e, a, b);
         end
         n_cmp++;
         if (rid !== 2'(i % 4)) begin
            n_mis++; $display("FAIL sweep_id[%0d]: got %0d want %0d", i, rid, i % 4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
